// File: rtl/quickq_pq.sv
// Sorted-array priority queue: insertion-scan enqueue, shift-down dequeue-min, single-cycle flush.
// One command in flight at a time; every accepted command ends with a one-cycle response pulse.
module quickq_pq #(
  parameter int unsigned KEY_W = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  input  logic [1:0]               cmd_op,
  input  logic [KEY_W-1:0]         cmd_key,
  output logic                     cmd_ready,
  output logic                     rsp_valid,
  output logic [KEY_W-1:0]         rsp_key,
  output logic                     rsp_err,
  output logic [KEY_W-1:0]         head_key,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [KEY_W-1:0] EMPTY_KEY = '1;

  typedef enum logic [1:0] {StIdle, StEnqScan, StDeqShift, StResp} state_e;

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  mem_q [DEPTH];
  logic [KEY_W-1:0]  mem_d [DEPTH];
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [KEY_W-1:0]  temp_q, temp_d;
  logic [KEY_W-1:0]  rsp_key_q, rsp_key_d;
  logic              rsp_err_q, rsp_err_d;
  logic [KEY_W-1:0]  head_q, head_d;
  logic              done;

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    count_d   = count_q;
    idx_d     = idx_q;
    temp_d    = temp_q;
    rsp_key_d = rsp_key_q;
    rsp_err_d = rsp_err_q;
    head_d    = head_q;
    done      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          rsp_key_d = EMPTY_KEY;
          rsp_err_d = 1'b0;
          state_d   = StResp;
          unique case (cmd_op)
            2'b00: begin
              if (full) begin
                rsp_err_d = 1'b1;
              end else begin
                temp_d  = cmd_key;
                idx_d   = '0;
                state_d = StEnqScan;
              end
            end
            2'b01: begin
              if (empty) begin
                rsp_err_d = 1'b1;
              end else begin
                rsp_key_d = mem_q[0];
                idx_d     = '0;
                state_d   = StDeqShift;
              end
            end
            2'b10: begin
              for (int i = 0; i < DEPTH; i++) mem_d[i] = EMPTY_KEY;
              count_d = '0;
              done    = 1'b1;
            end
            default: rsp_err_d = 1'b1;
          endcase
        end
      end

      StEnqScan: begin
        if ({1'b0, idx_q} == count_q) begin
          mem_d[idx_q] = temp_q;
          count_d      = count_q + CW'(1);
          state_d      = StResp;
          done         = 1'b1;
        end else begin
          // Strict compare keeps equal keys in arrival order.
          if (temp_q < mem_q[idx_q]) begin
            mem_d[idx_q] = temp_q;
            temp_d       = mem_q[idx_q];
          end
          idx_d = idx_q + AW'(1);
        end
      end

      StDeqShift: begin
        if ({1'b0, idx_q} == count_q - CW'(1)) begin
          mem_d[idx_q] = EMPTY_KEY;
          count_d      = count_q - CW'(1);
          state_d      = StResp;
          done         = 1'b1;
        end else begin
          mem_d[idx_q] = mem_q[idx_q + AW'(1)];
          idx_d        = idx_q + AW'(1);
        end
      end

      StResp: state_d = StIdle;

      default: state_d = StIdle;
    endcase

    // head_key is held separately so it only moves on the completing edge,
    // not while the scan or shift is rewriting mem[0].
    if (done) head_d = mem_d[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= EMPTY_KEY;
      count_q   <= '0;
      idx_q     <= '0;
      temp_q    <= '0;
      rsp_key_q <= EMPTY_KEY;
      rsp_err_q <= 1'b0;
      head_q    <= EMPTY_KEY;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      temp_q    <= temp_d;
      rsp_key_q <= rsp_key_d;
      rsp_err_q <= rsp_err_d;
      head_q    <= head_d;
    end
  end

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign rsp_valid = (state_q == StResp);
  assign rsp_key   = rsp_valid ? rsp_key_q : EMPTY_KEY;
  assign rsp_err   = rsp_valid & rsp_err_q;
  assign head_key  = head_q;
  assign count     = count_q;
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);

endmodule
